// File: rtl/mux_94_seq_if.sv
// Bundle of request, mux-control and output handshake signals for mux_94_seq.
// The master side issues requests and models the mux. The slave side is the sequencer.
interface mux_94_seq_if #(
    parameter int WIDTH = 9
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_src;
    logic [1:0]       mux_sel;
    logic             mux_lat;
    logic             mux_reset;
    logic [WIDTH-1:0] mux_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;

    modport master (
        output req_valid, req_src, mux_y, out_ready,
        input  req_ready, mux_sel, mux_lat, mux_reset, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_src, mux_y, out_ready,
        output req_ready, mux_sel, mux_lat, mux_reset, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_94_seq.sv
// Sequencer for the 4-input latching operand mux. It selects a source and waits for the mux output to settle.
// It then freezes the mux, captures its output and offers the word on a valid/ready handshake.
module mux_94_seq #(
    parameter int WIDTH         = 9,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    output logic         busy,
    mux_94_seq_if.slave  bus
);
    typedef enum logic [1:0] {CLEAR, IDLE, SETTLE, OUT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [1:0]       r_src_hold;
    logic [1:0]       r_mux_sel;
    logic             r_mux_lat;
    logic             r_mux_reset;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_src;
    logic             w_req_ready;
    logic             w_req_acc;
    logic             w_out_hs;

    // Flush cancels both handshakes in the cycle it is asserted.
    assign w_req_acc = bus.req_valid && w_req_ready && !flush;
    assign w_out_hs  = r_out_valid && bus.out_ready && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= CLEAR;
        else          r_state <= w_next;
    end

    // NOTE: the default assignment first means no path leaves w_next unassigned, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = CLEAR;
        end else begin
            case (r_state)
                CLEAR:  w_next = IDLE;
                IDLE:   if (w_req_acc) w_next = SETTLE;
                SETTLE: if (r_cnt == 4'd1) w_next = OUT;
                OUT:    if (w_out_hs) w_next = w_req_acc ? SETTLE : IDLE;
                default: w_next = CLEAR;
            endcase
        end
    end

    always_comb begin
        w_req_ready = 1'b0;
        case (r_state)
            IDLE:    w_req_ready = 1'b1;
            OUT:     w_req_ready = bus.out_ready;
            default: w_req_ready = 1'b0;
        endcase
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mux_sel   <= '0;
            r_mux_lat   <= 1'b0;
            r_mux_reset <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_src_hold  <= '0;
            r_cnt       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_mux_lat   <= 1'b0;
            r_mux_reset <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: r_mux_reset <= 1'b0;
                SETTLE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_out_data  <= bus.mux_y;
                        r_out_src   <= r_src_hold;
                        r_out_valid <= 1'b1;
                        r_mux_lat   <= 1'b1;
                    end
                end
                OUT: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_mux_lat   <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A request can be accepted in IDLE, or in OUT on the same edge that hands the word off.
            if (w_req_acc) begin
                r_mux_sel  <= bus.req_src;
                r_src_hold <= bus.req_src;
                r_cnt      <= 4'(SETTLE_CYCLES);
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.mux_sel   = r_mux_sel;
    assign bus.mux_lat   = r_mux_lat;
    assign bus.mux_reset = r_mux_reset;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
endmodule

// File: tb/tb_mux_94_seq.sv
// Directed bench for mux_94_seq. It includes a behavioural latching-mux model.
// A scoreboard queue holds the expected {src, data} for every accepted request.
module tb_mux_94_seq;
    typedef struct packed {
        logic [1:0] src;
        logic [8:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    logic busy;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    logic [8:0] in_val [4];
    logic [8:0] r_held;
    logic [8:0] w_live;
    exp_t       sb_q [$];
    int         hs_times [$];

    mux_94_seq_if #(.WIDTH(9)) bus ();

    mux_94_seq #(.WIDTH(9), .SETTLE_CYCLES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mux model: reset forces zero, and lat freezes the value seen on the edge where it rose.
    assign w_live = in_val[bus.mux_sel];
    always @(posedge clk) if (!bus.mux_lat) r_held <= w_live;
    assign bus.mux_y = bus.mux_reset ? 9'h000 : (bus.mux_lat ? r_held : w_live);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a request to be accepted, with a time limit. The expected word is pushed before the accepting edge.
    task automatic send(input logic [1:0] src, input bit keep);
        bus.req_valid = 1'b1;
        bus.req_src   = src;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_ready) break;
            tick();
        end
        check("req_accept", 32'(bus.req_ready), 32'd1);
        sb_q.push_back('{src: src, data: in_val[src]});
        tick();
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick();
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready && !flush) begin
            exp_t e;
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_src", 32'(bus.out_src), 32'(e.src));
            end
            hs_times.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_src   = 2'd0;
        bus.out_ready = 1'b0;
        in_val[0] = 9'h000; in_val[1] = 9'h000; in_val[2] = 9'h000; in_val[3] = 9'h000;

        // Reset and the single CLEAR cycle
        tick(); tick();
        check("rst_mux_reset", 32'(bus.mux_reset), 32'd1);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        #1;
        check("clear_mux_reset", 32'(bus.mux_reset), 32'd1);
        check("clear_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("idle_mux_reset", 32'(bus.mux_reset), 32'd0);
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Single fetch from c with out_ready low, to expose the latency
        in_val[2] = 9'h1A5;
        send(2'd2, 1'b0);
        check("f_mux_sel", 32'(bus.mux_sel), 32'd2);
        check("f_valid_n0", 32'(bus.out_valid), 32'd0);
        check("f_lat_n0", 32'(bus.mux_lat), 32'd0);
        tick();
        check("f_valid_n1", 32'(bus.out_valid), 32'd0);
        tick();
        check("f_valid_n2", 32'(bus.out_valid), 32'd1);
        check("f_lat_n2", 32'(bus.mux_lat), 32'd1);
        check("f_data", 32'(bus.out_data), 32'h1A5);
        check("f_src", 32'(bus.out_src), 32'd2);

        // Backpressure: the source changes while the word is held
        in_val[2] = 9'h0F0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data", 32'(bus.out_data), 32'h1A5);
            check("bp_lat", 32'(bus.mux_lat), 32'd1);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(bus.out_valid), 32'd0);
        check("bp_done_lat", 32'(bus.mux_lat), 32'd0);
        check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Back-to-back requests: one word every three clocks
        in_val[0] = 9'h001; in_val[1] = 9'h002; in_val[3] = 9'h1FF;
        hs_times.delete();
        send(2'd0, 1'b1);
        send(2'd1, 1'b1);
        send(2'd3, 1'b0);
        drain("b2b_drain");
        check("b2b_count", 32'(hs_times.size()), 32'd3);
        if (hs_times.size() == 3) begin
            check("b2b_gap1", 32'(hs_times[1] - hs_times[0]), 32'd3);
            check("b2b_gap2", 32'(hs_times[2] - hs_times[1]), 32'd3);
        end

        // Flush during SETTLE
        send(2'd2, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        void'(sb_q.pop_front());
        check("fs_mux_reset", 32'(bus.mux_reset), 32'd1);
        check("fs_valid", 32'(bus.out_valid), 32'd0);
        check("fs_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("fs_idle_ready", 32'(bus.req_ready), 32'd1);
        check("fs_idle_mux_reset", 32'(bus.mux_reset), 32'd0);

        // Flush during OUT while a request and an out handshake are also offered
        bus.out_ready = 1'b0;
        send(2'd1, 1'b0);
        tick(); tick();
        check("fo_valid", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_src   = 2'd3;
        tick();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        void'(sb_q.pop_front());
        check("fo_mux_reset", 32'(bus.mux_reset), 32'd1);
        check("fo_valid_drop", 32'(bus.out_valid), 32'd0);
        check("fo_lat", 32'(bus.mux_lat), 32'd0);
        check("fo_data_kept", 32'(bus.out_data), 32'h002);
        check("fo_src_kept", 32'(bus.out_src), 32'd1);
        check("fo_sel_kept", 32'(bus.mux_sel), 32'd1);
        tick();
        check("fo_idle_ready", 32'(bus.req_ready), 32'd1);
        send(2'd3, 1'b0);
        drain("fo_recover_drain");

        // Asynchronous reset between edges in SETTLE
        send(2'd2, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_mux_sel", 32'(bus.mux_sel), 32'd0);
        check("ar_mux_lat", 32'(bus.mux_lat), 32'd0);
        check("ar_mux_reset", 32'(bus.mux_reset), 32'd1);
        check("ar_out_valid", 32'(bus.out_valid), 32'd0);
        check("ar_out_data", 32'(bus.out_data), 32'd0);
        check("ar_out_src", 32'(bus.out_src), 32'd0);
        check("ar_req_ready", 32'(bus.req_ready), 32'd0);
        check("ar_busy", 32'(busy), 32'd1);
        sb_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        check("ar_idle_ready", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
